// File: rtl/apb_rm_pkg.sv
// Shared types, bus widths and helpers for the APB "rm" register-map responder.
// Imported by apb_rm_regfile and apb_reg_map.
package apb_rm_pkg;

    localparam int APB_ADDR_W     = 20;
    localparam int APB_DATA_W     = 16;
    localparam int APB_STRB_W     = 2;
    localparam int DEF_STATUS_IDX = 0;
    localparam int DEF_CTRL_IDX   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } rm_state_e;

    // Merge write data into the current word one byte lane at a time.
    function automatic logic [APB_DATA_W-1:0] strb_merge(
        input logic [APB_DATA_W-1:0] cur,
        input logic [APB_DATA_W-1:0] wdata,
        input logic [APB_STRB_W-1:0] strb
    );
        logic [APB_DATA_W-1:0] res;
        res = cur;
        for (int b = 0; b < APB_STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = cur[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/apb_rm_regfile.sv
// Register array for the rm map: byte-strobed write port, combinational read
// port with the hardware status overlay, and a direct tap of the control register.
module apb_rm_regfile
    import apb_rm_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int STATUS_IDX = DEF_STATUS_IDX,
    parameter int CTRL_IDX   = DEF_CTRL_IDX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_idx,
    input  logic [APB_DATA_W-1:0] wr_data,
    input  logic [APB_STRB_W-1:0] wr_strb,
    input  logic [7:0]            rd_idx,
    output logic [APB_DATA_W-1:0] rd_data,
    input  logic [APB_DATA_W-1:0] status_i,
    output logic [APB_DATA_W-1:0] ctrl_o
);

    localparam logic [7:0] STATUS_IDX_C = 8'(STATUS_IDX);

    logic [APB_DATA_W-1:0] regs_r [NUM_REGS];

    // Byte-strobed register update; the decoder never commits to the status slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == 8'(i)) begin
                    regs_r[i] <= strb_merge(regs_r[i], wr_data, wr_strb);
                end
            end
        end
    end

    // Read mux: status overlays its slot, unmatched indices read as zero.
    always_comb begin
        rd_data = 16'h0000;
        if (rd_idx == STATUS_IDX_C) begin
            rd_data = status_i;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rd_data = (rd_idx == 8'(i)) ? regs_r[i] : rd_data;
            end
        end
    end

    assign ctrl_o = regs_r[CTRL_IDX];

endmodule

// File: rtl/apb_reg_map.sv
// APB responder sitting behind secure_fsm: decodes word addresses into the rm
// register bank, inserts programmable wait states and returns a registered response.
module apb_reg_map
    import apb_rm_pkg::*;
#(
    parameter logic [19:0] BASE_ADDR   = 20'h00000,
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 4,
    parameter int          STATUS_IDX  = DEF_STATUS_IDX,
    parameter int          CTRL_IDX    = DEF_CTRL_IDX
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_STRB_W-1:0] pstrb,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [APB_DATA_W-1:0] status_i,
    output logic [APB_DATA_W-1:0] ctrl_o,
    output logic                  wr_pulse_o,
    output logic [7:0]            wr_idx_o
);

    localparam logic [19:0] NUM_REGS_C   = 20'(NUM_REGS);
    localparam logic [19:0] STATUS_IDX_C = 20'(STATUS_IDX);
    localparam logic [3:0]  WAIT_C       = 4'(WAIT_STATES);

    rm_state_e             state_r;
    logic [3:0]            cnt_r;
    logic [APB_ADDR_W-1:0] addr_r;
    logic                  write_r;
    logic [APB_STRB_W-1:0] strb_r;
    logic [APB_DATA_W-1:0] wdata_r;

    logic [APB_ADDR_W-1:0] sel_addr_s;
    logic                  sel_write_s;
    logic [APB_ADDR_W-1:0] idx_s;
    logic                  in_range_s;
    logic                  err_s;
    logic                  commit_s;
    logic [3:0]            cnt_next_s;
    logic [APB_DATA_W-1:0] rd_data_s;
    logic [APB_DATA_W-1:0] resp_data_s;

    // Decode the live bus while idle (zero-wait case), the latched request otherwise.
    always_comb begin
        if (state_r == IDLE) begin
            sel_addr_s  = paddr;
            sel_write_s = pwrite;
        end else begin
            sel_addr_s  = addr_r;
            sel_write_s = write_r;
        end
    end

    // Address decode, error classification and response data formation.
    always_comb begin
        idx_s      = sel_addr_s - BASE_ADDR;
        in_range_s = (sel_addr_s >= BASE_ADDR) && (idx_s < NUM_REGS_C);
        err_s      = !in_range_s || (sel_write_s && (idx_s == STATUS_IDX_C));
        if (err_s || sel_write_s) begin
            resp_data_s = 16'h0000;
        end else begin
            resp_data_s = rd_data_s;
        end
        commit_s   = (state_r == RESP) && write_r && !err_s;
        cnt_next_s = cnt_r + 4'd1;
    end

    // Transfer sequencer: state, wait counter, latched request and bus-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= 20'h00000;
            write_r    <= 1'b0;
            strb_r     <= 2'b00;
            wdata_r    <= 16'h0000;
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= 16'h0000;
            wr_pulse_o <= 1'b0;
            wr_idx_o   <= 8'h00;
        end else begin
            pready     <= 1'b0;
            pslverr    <= 1'b0;
            prdata     <= 16'h0000;
            wr_pulse_o <= commit_s;
            if (commit_s) begin
                wr_idx_o <= idx_s[7:0];
            end
            case (state_r)
                IDLE: begin
                    // An access phase without a preceding setup is ignored here.
                    if (psel && !penable) begin
                        addr_r  <= paddr;
                        write_r <= pwrite;
                        strb_r  <= pstrb;
                        wdata_r <= pwdata;
                        cnt_r   <= 4'd0;
                        if (WAIT_STATES == 0) begin
                            state_r <= RESP;
                            pready  <= 1'b1;
                            pslverr <= err_s;
                            prdata  <= resp_data_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!psel) begin
                        state_r <= IDLE;
                    end else if (penable) begin
                        cnt_r <= cnt_next_s;
                        if (cnt_next_s == WAIT_C) begin
                            state_r <= RESP;
                            pready  <= 1'b1;
                            pslverr <= err_s;
                            prdata  <= resp_data_s;
                        end
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    apb_rm_regfile #(
        .NUM_REGS   (NUM_REGS),
        .STATUS_IDX (STATUS_IDX),
        .CTRL_IDX   (CTRL_IDX)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (commit_s),
        .wr_idx   (idx_s[7:0]),
        .wr_data  (wdata_r),
        .wr_strb  (strb_r),
        .rd_idx   (idx_s[7:0]),
        .rd_data  (rd_data_s),
        .status_i (status_i),
        .ctrl_o   (ctrl_o)
    );

endmodule

// File: tb/tb_apb_reg_map.sv
// Scoreboard bench: one APB initiator drives a 4-wait-state and a 0-wait-state
// instance in parallel; a per-instance reference model predicts every response.
`timescale 1ns/1ps
module tb_apb_reg_map;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel, penable, pwrite;
    logic [1:0]  pstrb;
    logic [19:0] paddr;
    logic [15:0] pwdata, status_i;

    logic [1:0][15:0] prdata_v, ctrl_v;
    logic [1:0][7:0]  wr_idx_v;
    logic [1:0]       pready_v, pslverr_v, wr_pulse_v;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct { logic err; logic chk; logic [15:0] data; int cyc; } resp_t;
    typedef struct { logic [7:0] idx; logic [15:0] ctrl; int cyc; } wrx_t;
    resp_t rq0[$], rq1[$];
    wrx_t  wq0[$], wq1[$];
    logic [15:0] mregs [2][16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_reg_map #(.WAIT_STATES(4)) dut0 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]),
        .pready(pready_v[0]), .pslverr(pslverr_v[0]), .status_i(status_i),
        .ctrl_o(ctrl_v[0]), .wr_pulse_o(wr_pulse_v[0]), .wr_idx_o(wr_idx_v[0]));

    apb_reg_map #(.WAIT_STATES(0)) dut1 (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]),
        .pready(pready_v[1]), .pslverr(pslverr_v[1]), .status_i(status_i),
        .ctrl_o(ctrl_v[1]), .wr_pulse_o(wr_pulse_v[1]), .wr_idx_o(wr_idx_v[1]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decide the outcome of one completed transfer from the map rules.
    task automatic model(input int d, input logic w, input logic [19:0] a,
                         input logic [15:0] dat, input logic [1:0] s, input int n);
        int ws;
        int idx;
        logic err;
        logic [15:0] rd;
        resp_t r;
        wrx_t x;
        ws  = (d == 0) ? 4 : 0;
        idx = int'(a);
        err = (a >= 20'd16) || (w && a == 20'd0);
        rd  = 16'h0000;
        if (!err && w) begin
            if (s[0]) mregs[d][idx][7:0]  = dat[7:0];
            if (s[1]) mregs[d][idx][15:8] = dat[15:8];
            x.idx = 8'(idx); x.ctrl = mregs[d][1]; x.cyc = n + ws + 1;
            if (d == 0) wq0.push_back(x); else wq1.push_back(x);
        end else if (!err) begin
            rd = (idx == 0) ? status_i : mregs[d][idx];
        end
        r.err = err; r.chk = err || !w; r.data = rd; r.cyc = n + ws;
        if (d == 0) rq0.push_back(r); else rq1.push_back(r);
    endtask

    // hold = access cycles the initiator keeps psel up; 5 covers both instances.
    task automatic xfer(input logic w, input logic [19:0] a, input logic [15:0] dat,
                        input logic [1:0] s, input int hold);
        int n;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = dat; pstrb = s;
        tick();
        penable = 1'b1;
        n = cyc;
        if (hold > 4) model(0, w, a, dat, s, n);
        if (hold > 0) model(1, w, a, dat, s, n);
        for (int k = 1; k < hold; k++) tick();
        if (hold < 5) begin
            tick();
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic mon(input int d);
        resp_t r;
        wrx_t x;
        int n;
        if (pready_v[d]) begin
            n = (d == 0) ? rq0.size() : rq1.size();
            if (n == 0) begin
                chk($sformatf("dut%0d_unexpected_pready", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) r = rq0.pop_front(); else r = rq1.pop_front();
                chk($sformatf("dut%0d_pready_cycle", d), cyc, r.cyc);
                chk($sformatf("dut%0d_pslverr", d), {31'd0, pslverr_v[d]}, {31'd0, r.err});
                if (r.chk) chk($sformatf("dut%0d_prdata", d), {16'd0, prdata_v[d]}, {16'd0, r.data});
            end
        end else begin
            chk($sformatf("dut%0d_prdata_idle", d), {16'd0, prdata_v[d]}, 32'd0);
        end
        if (wr_pulse_v[d]) begin
            n = (d == 0) ? wq0.size() : wq1.size();
            if (n == 0) begin
                chk($sformatf("dut%0d_unexpected_wr_pulse", d), 32'd1, 32'd0);
            end else begin
                if (d == 0) x = wq0.pop_front(); else x = wq1.pop_front();
                chk($sformatf("dut%0d_wr_cycle", d), cyc, x.cyc);
                chk($sformatf("dut%0d_wr_idx", d), {24'd0, wr_idx_v[d]}, {24'd0, x.idx});
                chk($sformatf("dut%0d_ctrl", d), {16'd0, ctrl_v[d]}, {16'd0, x.ctrl});
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_dut%0d_outputs", tag, d),
                {prdata_v[d], ctrl_v[d]}, 32'd0);
            chk($sformatf("%s_dut%0d_flags", tag, d),
                {20'd0, wr_idx_v[d], 1'b0, pready_v[d], pslverr_v[d], wr_pulse_v[d]}, 32'd0);
        end
    endtask

    initial begin
        logic [19:0] a;
        int n;
        int r;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pstrb = 2'b00; paddr = 20'h00000; pwdata = 16'h0000; status_i = 16'h0000;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mregs[d][i] = 16'h0000;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;

        // Directed: full write/readback, byte lanes, errors, status, no-op strobe, abort.
        xfer(1'b1, 20'h00001, 16'h9432, 2'b11, 5);
        xfer(1'b0, 20'h00001, 16'h0000, 2'b11, 5);
        xfer(1'b1, 20'h00001, 16'hABCD, 2'b01, 5);
        xfer(1'b0, 20'h00001, 16'h0000, 2'b00, 5);
        xfer(1'b1, 20'h00001, 16'h1200, 2'b10, 5);
        xfer(1'b0, 20'h00001, 16'h0000, 2'b11, 5);
        xfer(1'b1, 20'h00123, 16'h5A5A, 2'b11, 5);
        xfer(1'b0, 20'h00111, 16'h0000, 2'b11, 5);
        status_i = 16'h1FA2;
        xfer(1'b0, 20'h00000, 16'h0000, 2'b11, 5);
        xfer(1'b1, 20'h00000, 16'hFFFF, 2'b11, 5);
        xfer(1'b1, 20'h00003, 16'hFFFF, 2'b00, 5);
        xfer(1'b0, 20'h0000F, 16'h0000, 2'b11, 5);
        xfer(1'b0, 20'h00010, 16'h0000, 2'b11, 5);
        xfer(1'b1, 20'h00002, 16'h7777, 2'b11, 1);
        xfer(1'b0, 20'h00002, 16'h0000, 2'b11, 5);

        // Reset pulse while the 4-wait instance is mid-transfer.
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00001; pwdata = 16'h5555; pstrb = 2'b11;
        tick();
        penable = 1'b1;
        n = cyc;
        model(1, 1'b1, 20'h00001, 16'h5555, 2'b11, n);
        tick();
        tick();
        reset = 1'b1;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) mregs[d][i] = 16'h0000;
        tick();
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        check_zero("midreset");
        xfer(1'b0, 20'h00001, 16'h0000, 2'b11, 5);

        // Randomized traffic including aborts, protocol violations and idle gaps.
        for (int it = 0; it < 200; it++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                tick();
                psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 20'($urandom_range(0, 15));
                pwdata = 16'($urandom); pstrb = 2'b11;
                tick();
                psel = 1'b0; penable = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) status_i = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 20'($urandom_range(16, 20'hFFFFF));
            else a = 20'($urandom_range(0, 17));
            xfer(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom_range(0, 3)),
                 (r == 1) ? $urandom_range(1, 3) : 5);
            if ($urandom_range(0, 5) == 0) begin
                tick();
                psel = 1'b0; penable = 1'b0;
            end
        end

        tick();
        psel = 1'b0; penable = 1'b0;
        repeat (10) tick();
        chk("dut0_resp_queue_drained", rq0.size(), 32'd0);
        chk("dut1_resp_queue_drained", rq1.size(), 32'd0);
        chk("dut0_wr_queue_drained", wq0.size(), 32'd0);
        chk("dut1_wr_queue_drained", wq1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
